// File: rtl/ball.sv
// Ball-motion unit: holds the ball position and per-axis velocity, steps the
// position on each movement tick during PLAY, and reflects velocity on
// collision flags and on the playfield walls.
module ball #(
  parameter logic [7:0] X_START = 8'd80,
  parameter logic [7:0] Y_START = 8'd100,
  parameter logic [7:0] X_MAX   = 8'd159,
  parameter logic [7:0] Y_MAX   = 8'd119
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       cX,
  input  logic       cY,
  output logic [7:0] nextX,
  output logic [7:0] nextY,
  output logic [2:0] vX,
  output logic [2:0] vY,
  input  logic       in
);

  // Game FSM encodings; every other value means FREEZE (hold everything).
  localparam logic [2:0] ST_READY = 3'b000;
  localparam logic [2:0] ST_PLAY  = 3'b001;

  // Start-of-serve velocity: +1 on X, -1 on Y.
  localparam logic [2:0] VX_START = 3'b001;
  localparam logic [2:0] VY_START = 3'b111;

  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] vx_q, vx_d;
  logic [2:0] vy_q, vy_d;

  logic [2:0]        evx, evy;
  logic signed [8:0] sx, sy;

  // Collision-adjusted velocity and the 9-bit signed candidate positions.
  // Magnitudes stay within 1..3, so two's-complement negation never wraps.
  always_comb begin
    evx = cX ? (3'd0 - vx_q) : vx_q;
    evy = cY ? (3'd0 - vy_q) : vy_q;
    sx  = $signed({1'b0, x_q}) + $signed({{6{evx[2]}}, evx});
    sy  = $signed({1'b0, y_q}) + $signed({{6{evy[2]}}, evy});
  end

  // Next-state selection: READY reloads, PLAY moves/reflects, FREEZE holds.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    vx_d = vx_q;
    vy_d = vy_q;
    if (state == ST_READY) begin
      x_d  = X_START;
      y_d  = Y_START;
      vx_d = VX_START;
      vy_d = VY_START;
    end else if (state == ST_PLAY) begin
      // Collisions always update velocity, even without a tick.
      vx_d = evx;
      vy_d = evy;
      if (in) begin
        // Wall reflection composes with any collision negation above.
        if (sx < 0) begin
          x_d  = 8'd0;
          vx_d = 3'd0 - evx;
        end else if (sx > $signed({1'b0, X_MAX})) begin
          x_d  = X_MAX;
          vx_d = 3'd0 - evx;
        end else begin
          x_d  = sx[7:0];
        end
        if (sy < 0) begin
          y_d  = 8'd0;
          vy_d = 3'd0 - evy;
        end else if (sy > $signed({1'b0, Y_MAX})) begin
          y_d  = Y_MAX;
          vy_d = 3'd0 - evy;
        end else begin
          y_d  = sy[7:0];
        end
      end
    end
  end

  // State registers with synchronous active-low reset overriding all inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q  <= X_START;
      y_q  <= Y_START;
      vx_q <= VX_START;
      vy_q <= VY_START;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
    end
  end

  assign nextX = x_q;
  assign nextY = y_q;
  assign vX    = vx_q;
  assign vY    = vy_q;

endmodule

// File: tb/tb_ball.sv
// Testbench for ball: directed steps push the expected (x, y, vx, vy) tuple
// into a queue; a negedge monitor pops and compares against the outputs.
module tb_ball;

  logic       clock;
  logic       reset;
  logic [2:0] state;
  logic       cX, cY, in;
  logic [7:0] nextX, nextY;
  logic [2:0] vX, vY;

  int checks   = 0;
  int failures = 0;

  // Expected tuple: {x[7:0], y[7:0], vx[2:0], vy[2:0]}
  logic [21:0] exp_q[$];

  ball dut (
    .clock (clock),
    .reset (reset),
    .state (state),
    .cX    (cX),
    .cY    (cY),
    .nextX (nextX),
    .nextY (nextY),
    .vX    (vX),
    .vY    (vY),
    .in    (in)
  );

  // Clock and initial input levels
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: compare outputs against the oldest expected tuple
  always @(negedge clock) begin
    logic [21:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {nextX, nextY, vX, vY};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL step%0d: got x=%0d y=%0d vx=%b vy=%b, expected x=%0d y=%0d vx=%b vy=%b",
                 checks, got[21:14], got[13:6], got[5:3], got[2:0],
                 exp[21:14], exp[13:6], exp[5:3], exp[2:0]);
      end
    end
  end

  // Driver: apply inputs for one edge and queue the expected result
  task automatic step(input logic rst, input logic [2:0] st, input logic cx,
                      input logic cy, input logic tick,
                      input logic [7:0] ex, input logic [7:0] ey,
                      input logic [2:0] evx, input logic [2:0] evy);
    reset = rst;
    state = st;
    cX    = cx;
    cY    = cy;
    in    = tick;
    @(posedge clock);
    #1;
    exp_q.push_back({ex, ey, evx, evy});
    @(negedge clock);
  endtask

  initial begin
    int wait_cycles;
    reset = 1'b0;
    state = 3'b001;
    cX    = 1'b0;
    cY    = 1'b0;
    in    = 1'b1;
    @(negedge clock);

    // Reset while PLAY with tick high
    step(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 8'd80, 8'd100, 3'b001, 3'b111);
    // Free flight
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd81, 8'd99, 3'b001, 3'b111);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd82, 8'd98, 3'b001, 3'b111);
    // X collision, then Y collision, then plain flight
    step(1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 8'd81, 8'd97, 3'b111, 3'b111);
    step(1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 8'd80, 8'd98, 3'b111, 3'b001);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd79, 8'd99, 3'b111, 3'b001);

    // Down-left until the bottom wall
    for (int n = 1; n <= 20; n++)
      step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'(79 - n), 8'(99 + n), 3'b111, 3'b001);
    // Bottom wall: clamp at 119, vy flips to -1
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd58, 8'd119, 3'b111, 3'b111);
    // Up-left until X reaches 0
    for (int k = 1; k <= 58; k++)
      step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'(58 - k), 8'(119 - k), 3'b111, 3'b111);
    // Left wall: clamp at 0, vx flips to +1
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd0, 8'd60, 3'b001, 3'b111);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd1, 8'd59, 3'b001, 3'b111);
    // Up-right until Y reaches 0
    for (int m = 1; m <= 59; m++)
      step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'(1 + m), 8'(59 - m), 3'b001, 3'b111);
    // Top wall: clamp at 0, vy flips to +1
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd61, 8'd0, 3'b001, 3'b001);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd62, 8'd1, 3'b001, 3'b001);
    // Down-right until X reaches 159
    for (int j = 1; j <= 97; j++)
      step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'(62 + j), 8'(1 + j), 3'b001, 3'b001);
    // Right wall: clamp at 159, vx flips to -1
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd159, 8'd99, 3'b111, 3'b001);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd158, 8'd100, 3'b111, 3'b001);

    // FREEZE ignores tick and collisions
    for (int f = 0; f < 5; f++)
      step(1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 8'd158, 8'd100, 3'b111, 3'b001);
    step(1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 8'd158, 8'd100, 3'b111, 3'b001);
    // READY reloads start values
    step(1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 8'd80, 8'd100, 3'b001, 3'b111);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 8'd80, 8'd100, 3'b001, 3'b111);

    // PLAY without tick: single cY pulse negates vy once, position holds
    step(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 8'd80, 8'd100, 3'b001, 3'b001);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 8'd80, 8'd100, 3'b001, 3'b001);
    // Both flags with tick: both axes reflect before moving
    step(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'd79, 8'd99, 3'b111, 3'b111);

    // Mid-flight reset during FREEZE restores start values
    step(1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 8'd80, 8'd100, 3'b001, 3'b111);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 8'd81, 8'd99, 3'b001, 3'b111);

    // Drain the queue with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
